// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan driver: glyph table,
// blank pattern and index-width helper.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {a,b,c,d,e,f,g} patterns for hex digits 0..F.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with a tear-free frame buffer,
// anti-ghost dead time, leading-zero blanking, decimal points and blinking.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int GHOST_CYCLES   = 16,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int CNT_W = idx_width(SCAN_DIV);
  localparam int FRM_W = idx_width(BLINK_FRAMES);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GHOST = CNT_W'(GHOST_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  // Pin-level XOR masks: zero for the default low-true wiring.
  localparam logic [6:0]            SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
  localparam logic                  DP_XOR  = (SEG_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic [NUM_DIGITS-1:0] AN_XOR  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b0}} : {NUM_DIGITS{1'b1}};

  logic [CNT_W-1:0]        cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic [FRM_W-1:0]        frm_r;
  logic                    blink_r;
  logic [4*NUM_DIGITS-1:0] pend_value_r, shad_value_r;
  logic [NUM_DIGITS-1:0]   pend_dp_r, shad_dp_r;
  logic [NUM_DIGITS-1:0]   pend_blink_r, shad_blink_r;

  logic                    slot_end_s, frame_end_s;
  logic [3:0]              nibble_s;
  logic                    digit_dp_s, digit_blink_s, upper_zero_s;
  logic                    blank_s;
  logic [NUM_DIGITS-1:0]   an_sel_s;
  logic [6:0]              glyph_s;

  assign slot_end_s  = (cnt_r == CNT_LAST);
  assign frame_end_s = slot_end_s && (idx_r == IDX_LAST);

  // Select the current digit from the shadow frame and evaluate its blanking.
  always_comb begin
    nibble_s      = 4'h0;
    digit_dp_s    = 1'b0;
    digit_blink_s = 1'b0;
    upper_zero_s  = 1'b1;
    an_sel_s      = {NUM_DIGITS{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_sel_s[i]   = (idx_r == IDX_W'(i));
      nibble_s      = an_sel_s[i] ? shad_value_r[4*i +: 4] : nibble_s;
      digit_dp_s    = an_sel_s[i] ? shad_dp_r[i] : digit_dp_s;
      digit_blink_s = an_sel_s[i] ? shad_blink_r[i] : digit_blink_s;
      upper_zero_s  = upper_zero_s & ~((i >= int'(idx_r)) & (|shad_value_r[4*i +: 4]));
    end
    blank_s = (blank_lz && (idx_r != IDX_W'(0)) && upper_zero_s) || (digit_blink_s && blink_r);
  end

  hex_to_seg u_hex_to_seg (
    .nibble (nibble_s),
    .glyph  (glyph_s)
  );

  // Scan counters, blink timing and the pending/shadow frame buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= '0;
      idx_r        <= '0;
      frm_r        <= '0;
      blink_r      <= 1'b0;
      pend_value_r <= '0;
      pend_dp_r    <= '0;
      pend_blink_r <= '0;
      shad_value_r <= '0;
      shad_dp_r    <= '0;
      shad_blink_r <= '0;
    end else begin
      if (slot_end_s) begin
        cnt_r <= '0;
        idx_r <= (idx_r == IDX_LAST) ? IDX_W'(0) : idx_r + IDX_W'(1);
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (load) begin
        pend_value_r <= value;
        pend_dp_r    <= dp_in;
        pend_blink_r <= blink_mask;
      end
      // A load landing on the boundary itself goes straight into the new frame.
      if (frame_end_s) begin
        shad_value_r <= load ? value      : pend_value_r;
        shad_dp_r    <= load ? dp_in      : pend_dp_r;
        shad_blink_r <= load ? blink_mask : pend_blink_r;
        if (frm_r == FRM_LAST) begin
          frm_r   <= '0;
          blink_r <= ~blink_r;
        end else begin
          frm_r <= frm_r + FRM_W'(1);
        end
      end
    end
  end

  // Registered pin outputs, one cycle behind the scan position.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg         <= SEG_BLANK ^ SEG_XOR;
      dp          <= 1'b1 ^ DP_XOR;
      an          <= {NUM_DIGITS{1'b1}} ^ AN_XOR;
      frame_start <= 1'b0;
    end else begin
      seg         <= (blank_s ? SEG_BLANK : glyph_s) ^ SEG_XOR;
      dp          <= ~(digit_dp_s && !blank_s) ^ DP_XOR;
      an          <= ((cnt_r >= CNT_GHOST) ? ~an_sel_s : {NUM_DIGITS{1'b1}}) ^ AN_XOR;
      frame_start <= frame_end_s;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed self-checking bench for seven_seg_scan_driver (4 digits, 4-clock slots).
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  blink_mask;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int n;
  int checks;
  int errors;
  int fs_count;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS     (4),
    .SCAN_DIV       (4),
    .GHOST_CYCLES   (1),
    .BLINK_FRAMES   (2),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .load        (load),
    .dp_in       (dp_in),
    .blink_mask  (blink_mask),
    .blank_lz    (blank_lz),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  // n counts clock edges since the last reset release; sampling is 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic goto(input int t);
    while (n < t) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic slot(input string tag, input int t, input logic [3:0] an_e,
                      input logic [6:0] seg_e, input logic dp_e);
    goto(t);
    chk({tag, ".an"}, 16'(an), 16'(an_e));
    chk({tag, ".seg"}, 16'(seg), 16'(seg_e));
    chk({tag, ".dp"}, 16'(dp), 16'(dp_e));
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value      = v;
    dp_in      = d;
    blink_mask = b;
    load       = 1'b1;
    tick();
    load       = 1'b0;
  endtask

  initial begin
    n = 0; checks = 0; errors = 0; fs_count = 0;
    rst = 1'b1; value = 16'h0000; load = 1'b0; dp_in = 4'h0;
    blink_mask = 4'h0; blank_lz = 1'b0;

    // 1. Reset and first slot
    repeat (3) tick();
    chk("rst.seg", 16'(seg), 16'h007F);
    chk("rst.dp", 16'(dp), 16'h0001);
    chk("rst.an", 16'(an), 16'h000F);
    chk("rst.fs", 16'(frame_start), 16'h0000);
    rst = 1'b0;
    n = 0;
    slot("s1.ghost", 1, 4'hF, 7'h01, 1'b1);
    slot("s1.d0", 2, 4'hE, 7'h01, 1'b1);

    // 2. Mid-frame load waits for the boundary
    goto(9);
    do_load(16'h12AF, 4'b0100, 4'b0000);
    slot("s2.old_d3", 15, 4'h7, 7'h01, 1'b1);
    goto(16);
    chk("s2.fs_hi", 16'(frame_start), 16'h0001);
    tick();
    chk("s2.fs_lo", 16'(frame_start), 16'h0000);
    slot("s2.d0", 18, 4'hE, 7'h38, 1'b1);
    slot("s2.d1", 22, 4'hD, 7'h08, 1'b1);
    slot("s2.d2", 26, 4'hB, 7'h12, 1'b0);
    slot("s2.d3", 30, 4'h7, 7'h4F, 1'b1);

    // 3. Leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0007, 4'b0000, 4'b0000);
    slot("s3.d0", 34, 4'hE, 7'h0F, 1'b1);
    slot("s3.d1", 38, 4'hD, 7'h7F, 1'b1);
    slot("s3.d2", 42, 4'hB, 7'h7F, 1'b1);
    slot("s3.d3", 46, 4'h7, 7'h7F, 1'b1);
    do_load(16'h0000, 4'b0000, 4'b0000);
    slot("s3.z0", 50, 4'hE, 7'h01, 1'b1);
    slot("s3.z1", 54, 4'hD, 7'h7F, 1'b1);
    slot("s3.z3", 62, 4'h7, 7'h7F, 1'b1);

    // 4. Load on the boundary cycle lands in the very next frame
    goto(63);
    blank_lz = 1'b0;
    do_load(16'h3456, 4'b0000, 4'b0000);
    chk("s4.fs_hi", 16'(frame_start), 16'h0001);
    chk("s4.old_seg", 16'(seg), 16'h0001);
    tick();
    chk("s4.fs_lo", 16'(frame_start), 16'h0000);
    slot("s4.d0", 66, 4'hE, 7'h20, 1'b1);
    slot("s4.d1", 70, 4'hD, 7'h24, 1'b1);
    slot("s4.d2", 74, 4'hB, 7'h4C, 1'b1);
    slot("s4.d3", 78, 4'h7, 7'h06, 1'b1);
    goto(80);
    chk("s4.fs_80", 16'(frame_start), 16'h0001);
    for (int i = 0; i < 16; i++) begin
      tick();
      fs_count += int'(frame_start);
    end
    chk("s4.fs_count", 16'(fs_count), 16'h0001);

    // 5. Blinking digit 0 (shown from frame 7, blink phase 1 there)
    do_load(16'h0008, 4'b0000, 4'b0001);
    slot("s5.f7_d0", 114, 4'hE, 7'h7F, 1'b1);
    slot("s5.f7_d1", 118, 4'hD, 7'h01, 1'b1);
    slot("s5.f8_d0", 130, 4'hE, 7'h00, 1'b1);
    slot("s5.f9_d0", 146, 4'hE, 7'h00, 1'b1);
    slot("s5.f10_d0", 162, 4'hE, 7'h7F, 1'b1);
    slot("s5.f10_d1", 166, 4'hD, 7'h01, 1'b1);

    // 6. Reset mid-scan (idx=2, cnt=2) with a coincident load that must be dropped
    goto(186);
    rst = 1'b1;
    value = 16'hFFFF; dp_in = 4'hF; blink_mask = 4'h0; load = 1'b1;
    tick();
    chk("s6.seg", 16'(seg), 16'h007F);
    chk("s6.dp", 16'(dp), 16'h0001);
    chk("s6.an", 16'(an), 16'h000F);
    chk("s6.fs", 16'(frame_start), 16'h0000);
    load = 1'b0;
    value = 16'h0000; dp_in = 4'h0;
    rst = 1'b0;
    n = 0;
    slot("s6.ghost", 1, 4'hF, 7'h01, 1'b1);
    slot("s6.d0", 2, 4'hE, 7'h01, 1'b1);
    slot("s6.d1", 6, 4'hD, 7'h01, 1'b1);
    goto(16);
    chk("s6.fs_hi", 16'(frame_start), 16'h0001);
    slot("s6.f1_d0", 18, 4'hE, 7'h01, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
